// File: rtl/pe_stream_acc.sv
// Processing element: selectable operands -> ALU/accumulator -> elastic output FIFO.
// Latency: a fire at cycle t shows on out_data_o at t+1 when the FIFO was empty.
// Backpressure: ready_o drops while the FIFO is full; nothing is lost. Optional macro PE_SAT_EN saturates ADD/SUB/ACC.
module pe_stream_acc #(
    parameter int DATA_W     = 32,
    parameter int N_NEIGH    = 4,
    parameter int RF_DEPTH   = 4,
    parameter int ACC_CNT_W  = 8,
    parameter int FIFO_DEPTH = 2,
    localparam int SEL_W     = $clog2(N_NEIGH + 3),
    localparam int RFI_W     = $clog2(RF_DEPTH)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic [2:0]                op_i,
    input  logic [SEL_W-1:0]          sel_a_i,
    input  logic [SEL_W-1:0]          sel_b_i,
    input  logic [DATA_W-1:0]         imm_i,
    input  logic [ACC_CNT_W-1:0]      acc_len_i,
    input  logic                      rf_wr_en_i,
    input  logic [RFI_W-1:0]          rf_wr_idx_i,
    input  logic [RFI_W-1:0]          rf_rd_idx_i,
    input  logic [N_NEIGH*DATA_W-1:0] neigh_data_i,
    input  logic [N_NEIGH-1:0]        neigh_valid_i,
    output logic                      ready_o,
    output logic [DATA_W-1:0]         out_data_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_ADD    = 3'd1;
    localparam logic [2:0] OP_SUB    = 3'd2;
    localparam logic [2:0] OP_MUL    = 3'd3;
    localparam logic [2:0] OP_MAX    = 3'd4;
    localparam logic [2:0] OP_ACC    = 3'd5;
    localparam logic [2:0] OP_ACCMAX = 3'd6;
    localparam logic [2:0] OP_PASS   = 3'd7;

    localparam logic [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

    // State
    logic [DATA_W-1:0]    r_self;
    logic [DATA_W-1:0]    r_rf  [RF_DEPTH];
    logic [DATA_W-1:0]    r_acc;
    logic [ACC_CNT_W-1:0] r_cnt;
    logic [DATA_W-1:0]    r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wptr;
    logic [PTR_W-1:0]     r_rptr;
    logic [CNT_W-1:0]     r_count;

    // Combinational nets
    logic [DATA_W:0]      w_opa;
    logic [DATA_W:0]      w_opb;
    logic [DATA_W-1:0]    w_a;
    logic [DATA_W-1:0]    w_b;
    logic                 w_a_vld;
    logic                 w_b_vld;
    logic [DATA_W-1:0]    w_rf_rd;
    logic                 w_need_b;
    logic                 w_is_acc;
    logic                 w_full;
    logic                 w_fire;
    logic                 w_push;
    logic                 w_pop;
    logic [DATA_W-1:0]    w_alu;
    logic [DATA_W-1:0]    w_acc_new;
    logic [DATA_W-1:0]    w_result;
    logic [ACC_CNT_W-1:0] w_len_eff;
    logic [ACC_CNT_W:0]   w_cnt_inc;
    logic                 w_acc_done;

    // Add, wrapping or clamped to the signed range
    function automatic logic [DATA_W-1:0] f_add(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] s;
        s = a + b;
`ifdef PE_SAT_EN
        if ((a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]))
            s = a[DATA_W-1] ? SMIN : SMAX;
`endif
        return s;
    endfunction

    // Subtract, wrapping or clamped to the signed range
    function automatic logic [DATA_W-1:0] f_sub(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] s;
        s = a - b;
`ifdef PE_SAT_EN
        if ((a[DATA_W-1] != b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]))
            s = a[DATA_W-1] ? SMIN : SMAX;
`endif
        return s;
    endfunction

    // Signed maximum
    function automatic logic [DATA_W-1:0] f_max(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    // Operand mux: returns {valid, data}; unused codes read as zero and invalid
    function automatic logic [DATA_W:0] f_operand(
        input logic [SEL_W-1:0]          sel,
        input logic [N_NEIGH*DATA_W-1:0] nd,
        input logic [N_NEIGH-1:0]        nv,
        input logic [DATA_W-1:0]         self_v,
        input logic [DATA_W-1:0]         rf_v,
        input logic [DATA_W-1:0]         imm_v
    );
        logic [DATA_W:0] r;
        r = '0;
        for (int i = 0; i < N_NEIGH; i++)
            if (sel == SEL_W'(i)) r = {nv[i], nd[i*DATA_W +: DATA_W]};
        if (sel == SEL_W'(N_NEIGH))     r = {1'b1, self_v};
        if (sel == SEL_W'(N_NEIGH + 1)) r = {1'b1, rf_v};
        if (sel == SEL_W'(N_NEIGH + 2)) r = {1'b1, imm_v};
        return r;
    endfunction

    // RF read returns the pre-write value since the write lands on the clock edge
    assign w_rf_rd = r_rf[rf_rd_idx_i];

    assign w_opa   = f_operand(sel_a_i, neigh_data_i, neigh_valid_i, r_self, w_rf_rd, imm_i);
    assign w_opb   = f_operand(sel_b_i, neigh_data_i, neigh_valid_i, r_self, w_rf_rd, imm_i);
    assign w_a     = w_opa[DATA_W-1:0];
    assign w_a_vld = w_opa[DATA_W];
    assign w_b     = w_opb[DATA_W-1:0];
    assign w_b_vld = w_opb[DATA_W];

    assign w_need_b = (op_i == OP_ADD) || (op_i == OP_SUB) || (op_i == OP_MUL) || (op_i == OP_MAX);
    assign w_is_acc = (op_i == OP_ACC) || (op_i == OP_ACCMAX);
    assign w_full   = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_fire   = (op_i != OP_NOP) && w_a_vld && (!w_need_b || w_b_vld)
                      && !w_full && !flush_i && !rst_i;
    assign ready_o  = w_fire;

    // Single-cycle ALU for the non-accumulating ops
    always_comb begin
        w_alu = w_a;
        case (op_i)
            OP_ADD:  w_alu = f_add(w_a, w_b);
            OP_SUB:  w_alu = f_sub(w_a, w_b);
            OP_MUL:  w_alu = w_a * w_b;
            OP_MAX:  w_alu = f_max(w_a, w_b);
            OP_PASS: w_alu = w_a;
            default: w_alu = w_a;
        endcase
    end

    // Accumulation step: first element of a run loads, later ones combine
    assign w_len_eff  = (acc_len_i == '0) ? ACC_CNT_W'(1) : acc_len_i;
    assign w_cnt_inc  = {1'b0, r_cnt} + 1'b1;
    assign w_acc_done = (w_cnt_inc >= {1'b0, w_len_eff});
    assign w_acc_new  = (r_cnt == '0) ? w_a :
                        (op_i == OP_ACC) ? f_add(r_acc, w_a) : f_max(r_acc, w_a);

    assign w_result = w_is_acc ? w_acc_new : w_alu;
    assign w_push   = w_fire && (!w_is_acc || w_acc_done);
    assign w_pop    = out_valid_o && out_ready_i;

    // Accumulator and run counter; cleared on completion, flush or reset
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_fire && w_is_acc) begin
            if (w_acc_done) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= w_acc_new;
                r_cnt <= w_cnt_inc[ACC_CNT_W-1:0];
            end
        end
    end

    // SELF and RF capture every pushed result; flush leaves them intact
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_self <= '0;
            for (int i = 0; i < RF_DEPTH; i++) r_rf[i] <= '0;
        end else if (w_push) begin
            r_self <= w_result;
            if (rf_wr_en_i) r_rf[rf_wr_idx_i] <= w_result;
        end
    end

    // Output ring buffer; flush empties it ahead of any push or pop
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            if (rst_i)
                for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_result;
                r_wptr <= (r_wptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop)
                r_rptr <= (r_rptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_push && w_pop)
                r_count <= r_count - 1'b1;
        end
    end

    assign out_valid_o = (r_count != '0);
    assign out_data_o  = out_valid_o ? r_mem[r_rptr] : '0;

endmodule
